// File: rtl/string_serializer.sv
// string_serializer
//   Accepts parallel words through a small FIFO and shifts each one out
//   MSB first, one bit per clock, to feed a serial string detector.
//   A separately loadable 4-bit pattern register drives the detector's
//   pattern input.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   in_data    : parallel word to serialize (WORD_W bits)
//   in_valid   : in_data valid this cycle
//   in_ready   : FIFO has room (fewer than DEPTH words held)
//   pat_data   : new 4-bit search pattern
//   pat_load   : load pat_data into the pattern register
//   string1    : registered pattern
//   string2    : serial data bit
//   bit_valid  : string2 carries a real data bit this cycle
//   busy       : FIFO non-empty or shifter active
//   words_sent : words fully shifted out, modulo 256
module string_serializer #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        pat_data,
  input  logic              pat_load,
  output logic [3:0]        string1,
  output logic              string2,
  output logic              bit_valid,
  output logic              busy,
  output logic [7:0]        words_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WORD_W);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [CW-1:0] ZERO_BIT = CW'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WORD_W-1:0]   fifo_mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [AW:0]         count_nxt_s;
  logic [WORD_W-1:0]   shift_r;
  logic [WORD_W-1:0]   shift_nxt_s;
  logic [CW-1:0]       bitcnt_r;
  logic [CW-1:0]       bitcnt_nxt_s;
  logic                push_s;
  logic                pop_s;
  logic                word_done_s;
  logic                in_ready_r;
  logic                busy_r;
  logic                bit_valid_r;
  logic [3:0]          pat_r;
  logic [7:0]          words_sent_r;

  // Push is gated on registered occupancy, so a full FIFO refuses even if it pops this edge.
  always_comb begin
    push_s = in_valid && (count_r != FULL_CNT);
  end

  // Shifter next-state: load on entry / word boundary, otherwise shift left.
  always_comb begin
    state_nxt_s  = state_r;
    shift_nxt_s  = shift_r;
    bitcnt_nxt_s = bitcnt_r;
    pop_s        = 1'b0;
    word_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != ZERO_CNT) begin
          pop_s        = 1'b1;
          shift_nxt_s  = fifo_mem_r[rd_ptr_r];
          bitcnt_nxt_s = LAST_BIT;
          state_nxt_s  = SHIFT;
        end else begin
          shift_nxt_s  = '0;
          bitcnt_nxt_s = ZERO_BIT;
        end
      end
      SHIFT: begin
        if (bitcnt_r == ZERO_BIT) begin
          word_done_s = 1'b1;
          // Reload on the same edge as the LSB ends so the stream has no bubble.
          if (count_r != ZERO_CNT) begin
            pop_s        = 1'b1;
            shift_nxt_s  = fifo_mem_r[rd_ptr_r];
            bitcnt_nxt_s = LAST_BIT;
          end else begin
            state_nxt_s  = IDLE;
            shift_nxt_s  = '0;
            bitcnt_nxt_s = ZERO_BIT;
          end
        end else begin
          shift_nxt_s  = {shift_r[WORD_W-2:0], 1'b0};
          bitcnt_nxt_s = bitcnt_r - CW'(1);
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        shift_nxt_s  = '0;
        bitcnt_nxt_s = ZERO_BIT;
      end
    endcase
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Shifter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= ZERO_CNT;
      shift_r      <= '0;
      bitcnt_r     <= ZERO_BIT;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      bit_valid_r  <= 1'b0;
      pat_r        <= 4'b0000;
      words_sent_r <= 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r     <= count_nxt_s;
      shift_r     <= shift_nxt_s;
      bitcnt_r    <= bitcnt_nxt_s;
      in_ready_r  <= (count_nxt_s != FULL_CNT);
      busy_r      <= (count_nxt_s != ZERO_CNT) || (state_nxt_s == SHIFT);
      bit_valid_r <= (state_nxt_s == SHIFT);
      if (word_done_s) begin
        words_sent_r <= words_sent_r + 8'd1;
      end
      if (pat_load) begin
        pat_r <= pat_data;
      end
    end
  end

  // shift_r is cleared whenever the shifter idles, so its MSB is 0 in IDLE.
  assign string2    = shift_r[WORD_W-1];
  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign bit_valid  = bit_valid_r;
  assign string1    = pat_r;
  assign words_sent = words_sent_r;

endmodule

// File: tb/tb_string_serializer.sv
// Testbench for string_serializer (WORD_W=8, DEPTH=4).
// Expected serial bits are queued when a word is driven and popped by a
// negedge monitor whenever bit_valid is high.
module tb_string_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] pat_data;
  logic       pat_load;
  logic [3:0] string1;
  logic       string2;
  logic       bit_valid;
  logic       busy;
  logic [7:0] words_sent;

  int   total;
  int   bad;
  logic sb[$];
  int   valid_cycles;
  int   run_len;
  int   last_run;
  logic mon_en;

  string_serializer #(.WORD_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pat_data   (pat_data),
    .pat_load   (pat_load),
    .string1    (string1),
    .string2    (string2),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic sb_word(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) sb.push_back(w[b]);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!(busy === 1'b0 && sb.size() == 0) && n < max_cycles) begin
      tick;
      n++;
    end
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    tick;
  endtask

  // Monitor: every valid bit must match the scoreboard head; idle string2 must be 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bit_valid === 1'b1) begin
        valid_cycles++;
        run_len++;
        if (sb.size() == 0) begin
          chk("unexpected_bit", 32'd1, 32'd0);
        end else begin
          chk("serial_bit", {31'd0, string2}, {31'd0, sb.pop_front()});
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        chk("idle_string2", {31'd0, string2}, 32'd0);
      end
    end
  end

  logic exp_rdy [12];
  int   vc0;

  initial begin
    total = 0; bad = 0; valid_cycles = 0; run_len = 0; last_run = 0; mon_en = 1'b0;
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; pat_data = 4'h0; pat_load = 1'b0;
    tick; tick;
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_bit_valid",  {31'd0, bit_valid},  32'd0);
    chk("rst_string2",    {31'd0, string2},    32'd0);
    chk("rst_string1",    {28'd0, string1},    32'd0);
    chk("rst_words_sent", {24'd0, words_sent}, 32'd0);

    // Pattern load
    pat_data = 4'b0110; pat_load = 1'b1;
    tick;
    pat_load = 1'b0;
    chk("pat_string1", {28'd0, string1}, 32'h6);
    chk("pat_string2", {31'd0, string2}, 32'd0);
    chk("pat_bit_valid", {31'd0, bit_valid}, 32'd0);

    // Single word, latency and bit count
    vc0 = valid_cycles;
    in_valid = 1'b1; in_data = 8'b01100110;
    chk("single_in_ready", {31'd0, in_ready}, 32'd1);
    sb_word(8'b01100110);
    tick;
    in_valid = 1'b0;
    chk("single_lat_bv0", {31'd0, bit_valid}, 32'd0);
    chk("single_lat_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("single_lat_bv1", {31'd0, bit_valid}, 32'd1);
    chk("single_msb", {31'd0, string2}, 32'd0);
    wait_idle("single", 40);
    chk("single_valid_cnt", valid_cycles - vc0, 32'd8);
    chk("single_run", last_run, 32'd8);
    chk("single_words", {24'd0, words_sent}, 32'd1);

    // Back-to-back words, with a pattern load mid-stream
    vc0 = valid_cycles;
    in_valid = 1'b1; in_data = 8'hA5; sb_word(8'hA5);
    tick;
    in_data = 8'h3C; sb_word(8'h3C);
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    pat_data = 4'b1001; pat_load = 1'b1;
    tick;
    pat_load = 1'b0;
    chk("mid_pat_string1", {28'd0, string1}, 32'h9);
    chk("mid_pat_bv", {31'd0, bit_valid}, 32'd1);
    wait_idle("b2b", 60);
    chk("b2b_run", last_run, 32'd16);
    chk("b2b_valid_cnt", valid_cycles - vc0, 32'd16);
    chk("b2b_words", {24'd0, words_sent}, 32'd3);

    // Full FIFO: new word offered every cycle
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data = 8'h10 + 8'(i);
      chk($sformatf("full_in_ready_%0d", i), {31'd0, in_ready}, {31'd0, exp_rdy[i]});
      if (exp_rdy[i]) sb_word(8'h10 + 8'(i));
      tick;
    end
    in_valid = 1'b0;
    wait_idle("full", 120);
    chk("full_words", {24'd0, words_sent}, 32'd9);

    // Reset mid-word with two words queued
    in_valid = 1'b1; in_data = 8'hFF; sb_word(8'hFF);
    tick;
    in_data = 8'h81; sb_word(8'h81);
    tick;
    in_data = 8'h42; sb_word(8'h42);
    tick;
    in_valid = 1'b0;
    tick;
    chk("prerst_bv", {31'd0, bit_valid}, 32'd1);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h77; pat_load = 1'b1; pat_data = 4'hF;
    tick;
    sb.delete();
    vc0 = valid_cycles;
    chk("mid_rst_bv", {31'd0, bit_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_words", {24'd0, words_sent}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_string1", {28'd0, string1}, 32'd0);
    reset = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    repeat (20) tick;
    chk("post_rst_no_bits", valid_cycles - vc0, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Counter wrap: 256 words, one every 8 cycles
    vc0 = valid_cycles;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i);
      chk($sformatf("wrap_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      sb_word(8'(i));
      tick;
      in_valid = 1'b0;
      repeat (7) tick;
    end
    wait_idle("wrap", 60);
    chk("wrap_valid_cnt", valid_cycles - vc0, 32'd2048);
    chk("wrap_words", {24'd0, words_sent}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
